arp_resolver: RTL and testbench

Address-resolution front end that sits directly upstream of the ARP cache and drives its query port. It takes a next-hop resolution request for an IPv4 destination and applies subnet and gateway selection plus broadcast short-cut. It queries the cache, and on a miss commands the ARP TX path to emit ARP requests with bounded retries. It then returns a MAC address or an error to the IP TX path.

---
 rtl/arp_resolver_pkg.sv | 19 +
 rtl/arp_resolver_if.sv | 44 ++++
 rtl/arp_resolver.sv | 159 +++++++++++++++
 tb/tb_arp_resolver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arp_resolver_pkg.sv
// rtl/arp_resolver_pkg.sv - shared Ethernet/IPv4 constants and next-hop classification helpers
package arp_resolver_pkg;

  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] IPV4_BCAST    = 32'hFFFF_FFFF;

  function automatic logic ip_off_subnet(input logic [31:0] ip, input logic [31:0] lip,
                                         input logic [31:0] mask);
    return ((ip ^ lip) & mask) != 32'd0;
  endfunction

  // Limited broadcast, or the directed broadcast of our own subnet.
  function automatic logic ip_is_bcast(input logic [31:0] ip, input logic [31:0] lip,
                                       input logic [31:0] mask);
    return (ip == IPV4_BCAST) ||
           (!ip_off_subnet(ip, lip, mask) && ((ip | mask) == IPV4_BCAST));
  endfunction

endpackage

// File: rtl/arp_resolver_if.sv
// rtl/arp_resolver_if.sv - resolver bus: request/response, cache query/result, cache write snoop, ARP TX, config
interface arp_resolver_if;
  logic        arp_request_valid;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid;
  logic        arp_response_ready;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;
  logic        cache_query_valid;
  logic        cache_query_ready;
  logic [31:0] cache_query_ip;
  logic        cache_resp_valid;
  logic        cache_resp_ready;
  logic        cache_resp_error;
  logic [47:0] cache_resp_mac;
  logic        cache_write_valid;
  logic        cache_write_ready;
  logic [31:0] cache_write_ip;
  logic        tx_req_valid;
  logic        tx_req_ready;
  logic [31:0] tx_req_ip;
  logic [31:0] local_ip;
  logic [31:0] gateway_ip;
  logic [31:0] subnet_mask;

  modport master (
    input  arp_request_valid, arp_request_ip, arp_response_ready,
    input  cache_query_ready, cache_resp_valid, cache_resp_error, cache_resp_mac,
    input  cache_write_valid, cache_write_ready, cache_write_ip, tx_req_ready,
    input  local_ip, gateway_ip, subnet_mask,
    output arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
    output cache_query_valid, cache_query_ip, cache_resp_ready, tx_req_valid, tx_req_ip
  );

  modport slave (
    output arp_request_valid, arp_request_ip, arp_response_ready,
    output cache_query_ready, cache_resp_valid, cache_resp_error, cache_resp_mac,
    output cache_write_valid, cache_write_ready, cache_write_ip, tx_req_ready,
    output local_ip, gateway_ip, subnet_mask,
    input  arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
    input  cache_query_valid, cache_query_ip, cache_resp_ready, tx_req_valid, tx_req_ip
  );
endinterface

// File: rtl/arp_resolver.sv
// rtl/arp_resolver.sv - next-hop MAC resolution: classify, query cache, retry ARP requests, respond
module arp_resolver
  import arp_resolver_pkg::*;
#(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 250000000
) (
  input logic            clk,
  input logic            rst,
  arp_resolver_if.master io_arp
);

  localparam int CNT_W = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;
  localparam int TMR_W = (RETRY_INTERVAL > 1) ? $clog2(RETRY_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RETRY_COUNT);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(RETRY_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_QUERY      = 3'd1,
    S_WAIT_RESP  = 3'd2,
    S_SEND_REQ   = 3'd3,
    S_WAIT_RETRY = 3'd4,
    S_RESPOND    = 3'd5
  } state_t;

  state_t           r_state;
  logic [31:0]      r_target;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_resp_error;
  logic [47:0]      r_resp_mac;
  logic             r_query_valid;
  logic [31:0]      r_query_ip;
  logic             r_cresp_ready;
  logic             r_tx_valid;
  logic [31:0]      r_tx_ip;

  logic             w_off_subnet;
  logic             w_bcast;
  logic             w_snoop_hit;
  logic [31:0]      w_target;

  assign w_off_subnet = ip_off_subnet(io_arp.arp_request_ip, io_arp.local_ip, io_arp.subnet_mask);
  assign w_bcast      = ip_is_bcast(io_arp.arp_request_ip, io_arp.local_ip, io_arp.subnet_mask);
  assign w_target     = w_off_subnet ? io_arp.gateway_ip : io_arp.arp_request_ip;
  assign w_snoop_hit  = io_arp.cache_write_valid && io_arp.cache_write_ready &&
                        (io_arp.cache_write_ip == r_target);

  assign io_arp.arp_request_ready  = r_req_ready;
  assign io_arp.arp_response_valid = r_resp_valid;
  assign io_arp.arp_response_error = r_resp_error;
  assign io_arp.arp_response_mac   = r_resp_mac;
  assign io_arp.cache_query_valid  = r_query_valid;
  assign io_arp.cache_query_ip     = r_query_ip;
  assign io_arp.cache_resp_ready   = r_cresp_ready;
  assign io_arp.tx_req_valid       = r_tx_valid;
  assign io_arp.tx_req_ip          = r_tx_ip;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_target      <= '0;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_error  <= 1'b0;
      r_resp_mac    <= '0;
      r_query_valid <= 1'b0;
      r_query_ip    <= '0;
      r_cresp_ready <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_ip       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && io_arp.arp_request_valid) begin
            r_req_ready <= 1'b0;
            if (w_bcast) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_resp_mac   <= ETH_BCAST_MAC;
              r_state      <= S_RESPOND;
            end else if (w_off_subnet && (io_arp.gateway_ip == 32'd0)) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_mac   <= '0;
              r_state      <= S_RESPOND;
            end else begin
              r_target      <= w_target;
              r_query_ip    <= w_target;
              r_query_valid <= 1'b1;
              r_cnt         <= CNT_INIT;
              r_state       <= S_QUERY;
            end
          end
        end
        S_QUERY: begin
          if (io_arp.cache_query_ready) begin
            r_query_valid <= 1'b0;
            r_cresp_ready <= 1'b1;
            r_state       <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (io_arp.cache_resp_valid) begin
            r_cresp_ready <= 1'b0;
            if (!io_arp.cache_resp_error) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_resp_mac   <= io_arp.cache_resp_mac;
              r_state      <= S_RESPOND;
            end else if (r_cnt == '0) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_mac   <= '0;
              r_state      <= S_RESPOND;
            end else begin
              r_tx_valid <= 1'b1;
              r_tx_ip    <= r_target;
              r_state    <= S_SEND_REQ;
            end
          end
        end
        S_SEND_REQ: begin
          if (io_arp.tx_req_ready) begin
            r_tx_valid <= 1'b0;
            r_cnt      <= r_cnt - 1'b1;
            r_timer    <= TMR_INIT;
            r_state    <= S_WAIT_RETRY;
          end
        end
        S_WAIT_RETRY: begin
          // A snooped cache fill for our target cuts the wait short.
          if ((r_timer == '0) || w_snoop_hit) begin
            r_query_valid <= 1'b1;
            r_query_ip    <= r_target;
            r_state       <= S_QUERY;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_RESPOND: begin
          if (io_arp.arp_response_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_resolver.sv
// tb/tb_arp_resolver.sv - directed self-checking bench for arp_resolver
module tb_arp_resolver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_hs = 0;

  arp_resolver_if bus ();

  arp_resolver #(.RETRY_COUNT(2), .RETRY_INTERVAL(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_arp(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return bus.cache_query_valid;
      1:       return bus.tx_req_valid;
      2:       return bus.arp_response_valid;
      default: return bus.cache_resp_ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (!sel(which) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(sel(which)), 64'd1);
  endtask

  task automatic do_request(input logic [31:0] ip);
    bus.arp_request_valid = 1'b1;
    bus.arp_request_ip    = ip;
    tick();
    bus.arp_request_valid = 1'b0;
  endtask

  task automatic query_hs(input logic [31:0] ip, input string tag);
    wait_sig(0, {tag, "_qvalid"});
    check({tag, "_qip"}, 64'(bus.cache_query_ip), 64'(ip));
    bus.cache_query_ready = 1'b1;
    tick();
    bus.cache_query_ready = 1'b0;
  endtask

  task automatic cache_reply(input logic err, input logic [47:0] mac);
    check("cresp_ready", 64'(bus.cache_resp_ready), 64'd1);
    bus.cache_resp_valid = 1'b1;
    bus.cache_resp_error = err;
    bus.cache_resp_mac   = mac;
    tick();
    bus.cache_resp_valid = 1'b0;
  endtask

  task automatic tx_hs(input logic [31:0] ip, input string tag);
    wait_sig(1, {tag, "_txvalid"});
    check({tag, "_txip"}, 64'(bus.tx_req_ip), 64'(ip));
    bus.tx_req_ready = 1'b1;
    tick();
    bus.tx_req_ready = 1'b0;
    t_hs = cyc;
  endtask

  task automatic expect_resp(input string tag, input logic err, input logic [47:0] mac);
    check({tag, "_rvalid"}, 64'(bus.arp_response_valid), 64'd1);
    check({tag, "_rerr"}, 64'(bus.arp_response_error), 64'(err));
    check({tag, "_rmac"}, 64'(bus.arp_response_mac), 64'(mac));
  endtask

  task automatic finish_resp();
    bus.arp_response_ready = 1'b1;
    tick();
    bus.arp_response_ready = 1'b0;
    check("post_resp_valid", 64'(bus.arp_response_valid), 64'd0);
    check("post_resp_ready", 64'(bus.arp_request_ready), 64'd1);
  endtask

  initial begin
    bus.arp_request_valid  = 1'b0;
    bus.arp_request_ip     = '0;
    bus.arp_response_ready = 1'b0;
    bus.cache_query_ready  = 1'b0;
    bus.cache_resp_valid   = 1'b0;
    bus.cache_resp_error   = 1'b0;
    bus.cache_resp_mac     = '0;
    bus.cache_write_valid  = 1'b0;
    bus.cache_write_ready  = 1'b0;
    bus.cache_write_ip     = '0;
    bus.tx_req_ready       = 1'b0;
    bus.local_ip           = 32'hC0A8_0164;
    bus.gateway_ip         = 32'hC0A8_0101;
    bus.subnet_mask        = 32'hFFFF_FF00;

    // Reset values
    repeat (3) tick();
    check("rst_req_ready", 64'(bus.arp_request_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.arp_response_valid), 64'd0);
    check("rst_query_valid", 64'(bus.cache_query_valid), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_req_valid), 64'd0);
    check("rst_cresp_ready", 64'(bus.cache_resp_ready), 64'd0);
    check("rst_err", 64'(bus.arp_response_error), 64'd0);
    check("rst_mac", 64'(bus.arp_response_mac), 64'd0);
    check("rst_txip", 64'(bus.tx_req_ip), 64'd0);
    check("rst_qip", 64'(bus.cache_query_ip), 64'd0);
    rst = 1'b0;
    tick();
    check("rel_req_ready", 64'(bus.arp_request_ready), 64'd1);

    // Cache hit on-subnet; query valid the cycle after accept
    do_request(32'hC0A8_0105);
    check("hit_qvalid_n1", 64'(bus.cache_query_valid), 64'd1);
    check("hit_req_ready", 64'(bus.arp_request_ready), 64'd0);
    query_hs(32'hC0A8_0105, "hit");
    cache_reply(1'b0, 48'h0200_0000_0005);
    expect_resp("hit", 1'b0, 48'h0200_0000_0005);
    check("hit_no_tx", 64'(bus.tx_req_valid), 64'd0);
    finish_resp();

    // Off-subnet goes to the gateway
    do_request(32'h0808_0808);
    query_hs(32'hC0A8_0101, "gw");
    cache_reply(1'b0, 48'h0200_0000_00AA);
    expect_resp("gw", 1'b0, 48'h0200_0000_00AA);
    finish_resp();

    // Directed and limited broadcast short-cuts
    do_request(32'hC0A8_01FF);
    expect_resp("dbc", 1'b0, 48'hFFFF_FFFF_FFFF);
    check("dbc_noq", 64'(bus.cache_query_valid), 64'd0);
    finish_resp();
    do_request(32'hFFFF_FFFF);
    expect_resp("lbc", 1'b0, 48'hFFFF_FFFF_FFFF);
    check("lbc_noq", 64'(bus.cache_query_valid), 64'd0);
    finish_resp();

    // Off-subnet with no gateway
    bus.gateway_ip = 32'd0;
    do_request(32'h0808_0808);
    expect_resp("nogw", 1'b1, 48'd0);
    check("nogw_noq", 64'(bus.cache_query_valid), 64'd0);
    finish_resp();
    bus.gateway_ip = 32'hC0A8_0101;

    // Retry exhaustion: 3 queries, 2 ARP requests, interval 16
    do_request(32'hC0A8_0107);
    query_hs(32'hC0A8_0107, "ex1");
    cache_reply(1'b1, 48'd0);
    tx_hs(32'hC0A8_0107, "ex_tx1");
    wait_sig(0, "ex_q2_valid");
    check("ex_interval1", 64'(cyc - t_hs), 64'd16);
    query_hs(32'hC0A8_0107, "ex2");
    cache_reply(1'b1, 48'd0);
    tx_hs(32'hC0A8_0107, "ex_tx2");
    wait_sig(0, "ex_q3_valid");
    check("ex_interval2", 64'(cyc - t_hs), 64'd16);
    query_hs(32'hC0A8_0107, "ex3");
    cache_reply(1'b1, 48'd0);
    expect_resp("ex", 1'b1, 48'd0);
    check("ex_no_tx3", 64'(bus.tx_req_valid), 64'd0);
    finish_resp();

    // Snoop: non-matching write ignored, matching write at +5 re-queries at +6
    do_request(32'hC0A8_0109);
    query_hs(32'hC0A8_0109, "snp1");
    cache_reply(1'b1, 48'd0);
    tx_hs(32'hC0A8_0109, "snp_tx");
    repeat (2) tick();
    bus.cache_write_valid = 1'b1;
    bus.cache_write_ready = 1'b1;
    bus.cache_write_ip    = 32'hC0A8_010A;
    tick();
    bus.cache_write_valid = 1'b0;
    check("snp_nomatch", 64'(bus.cache_query_valid), 64'd0);
    repeat (2) tick();
    bus.cache_write_valid = 1'b1;
    bus.cache_write_ip    = 32'hC0A8_0109;
    check("snp_before", 64'(bus.cache_query_valid), 64'd0);
    tick();
    bus.cache_write_valid = 1'b0;
    check("snp_requery", 64'(bus.cache_query_valid), 64'd1);
    check("snp_offset", 64'(cyc - t_hs), 64'd6);
    query_hs(32'hC0A8_0109, "snp2");
    cache_reply(1'b0, 48'h0200_0000_000B);
    expect_resp("snp", 1'b0, 48'h0200_0000_000B);

    // Backpressure: response held stable
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(bus.arp_response_valid), 64'd1);
      check("bp_mac", 64'(bus.arp_response_mac), 64'h0200_0000_000B);
    end
    finish_resp();

    // Reset during WAIT_RETRY abandons the request
    do_request(32'hC0A8_010B);
    query_hs(32'hC0A8_010B, "rr");
    cache_reply(1'b1, 48'd0);
    tx_hs(32'hC0A8_010B, "rr_tx");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rr_qvalid", 64'(bus.cache_query_valid), 64'd0);
    check("rr_txvalid", 64'(bus.tx_req_valid), 64'd0);
    check("rr_rvalid", 64'(bus.arp_response_valid), 64'd0);
    check("rr_ready_in_rst", 64'(bus.arp_request_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("rr_ready_rel", 64'(bus.arp_request_ready), 64'd1);
    repeat (20) tick();
    check("rr_no_query", 64'(bus.cache_query_valid), 64'd0);
    check("rr_no_resp", 64'(bus.arp_response_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
